// File: rtl/memory_inhibit_3.sv
// memory_inhibit_3: core-memory restore cycle sequencer driving inhibit and write strobes
module memory_inhibit_3 #(
   parameter int INH_CYCLES = 4,
   parameter int REC_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_start,
   input  logic [2:0] m_sel,
   input  logic       duplex,
   input  logic       bra6,
   input  logic       bra9,
   input  logic       bra12,
   input  logic       bra14,
   input  logic       brb6,
   input  logic       brb9,
   input  logic       brb12,
   input  logic       brb14,
   output logic [7:0] mih6,
   output logic [7:0] mih9,
   output logic [7:0] mih12,
   output logic [7:0] mih14,
   output logic [7:0] mwr,
   output logic       busy,
   output logic       done,
   output logic       start_err
);
   typedef enum logic [2:0] {IDLE, LEAD, WRITE, TRAIL, RECOVER} state_t;
   localparam logic [3:0] INH_L = 4'(INH_CYCLES - 1);
   localparam logic [3:0] REC_L = 4'(REC_CYCLES - 1);
   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] sel_q, sel_d;
   logic       dup_q, dup_d;
   logic [3:0] ba_q, ba_d, bb_q, bb_d;
   logic [7:0] mih6_q, mih9_q, mih12_q, mih14_q, mwr_q;
   logic [7:0] mih6_d, mih9_d, mih12_d, mih14_d, mwr_d;
   logic       busy_q, done_q, start_err_q;
   logic       act, wr;
   logic [7:0] sel;
   // next state, cycle counter reload and start-time capture of target and buffer bits
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      dup_d   = dup_q;
      ba_d    = ba_q;
      bb_d    = bb_q;
      case (state_q)
         IDLE: if (wr_start) begin
            state_d = LEAD;
            cnt_d   = '0;
            sel_d   = m_sel;
            dup_d   = duplex;
            ba_d    = {bra14, bra12, bra9, bra6};
            bb_d    = {brb14, brb12, brb9, brb6};
         end
         LEAD: begin
            state_d = WRITE;
            cnt_d   = INH_L;
         end
         WRITE: begin
            state_d = cnt_q == '0 ? TRAIL : WRITE;
            cnt_d   = cnt_q == '0 ? '0 : cnt_q - 4'd1;
         end
         TRAIL: begin
            state_d = RECOVER;
            cnt_d   = REC_L;
         end
         RECOVER: begin
            state_d = cnt_q == '0 ? IDLE : RECOVER;
            cnt_d   = cnt_q == '0 ? '0 : cnt_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
   end
   assign act = state_d inside {LEAD, WRITE, TRAIL};
   assign wr  = state_d == WRITE;
   // even modules take channel A bits, odd modules channel B, in both modes
   for (genvar k = 0; k < 8; k++) begin : g_mod
      assign sel[k]     = dup_d ? (sel_d[2:1] == 2'(k / 2)) : (sel_d == 3'(k));
      assign mih6_d[k]  = act & sel[k] & ~((k % 2 == 1) ? bb_d[0] : ba_d[0]);
      assign mih9_d[k]  = act & sel[k] & ~((k % 2 == 1) ? bb_d[1] : ba_d[1]);
      assign mih12_d[k] = act & sel[k] & ~((k % 2 == 1) ? bb_d[2] : ba_d[2]);
      assign mih14_d[k] = act & sel[k] & ~((k % 2 == 1) ? bb_d[3] : ba_d[3]);
      assign mwr_d[k]   = wr & sel[k];
   end
   // state, latches and output registers; outputs are computed from next state so they align with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sel_q       <= '0;
         dup_q       <= 1'b0;
         ba_q        <= '0;
         bb_q        <= '0;
         mih6_q      <= '0;
         mih9_q      <= '0;
         mih12_q     <= '0;
         mih14_q     <= '0;
         mwr_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         start_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sel_q       <= sel_d;
         dup_q       <= dup_d;
         ba_q        <= ba_d;
         bb_q        <= bb_d;
         mih6_q      <= mih6_d;
         mih9_q      <= mih9_d;
         mih12_q     <= mih12_d;
         mih14_q     <= mih14_d;
         mwr_q       <= mwr_d;
         busy_q      <= state_d != IDLE;
         done_q      <= state_q == RECOVER && state_d == IDLE;
         start_err_q <= wr_start && state_q != IDLE;
      end
   end
   assign mih6      = mih6_q;
   assign mih9      = mih9_q;
   assign mih12     = mih12_q;
   assign mih14     = mih14_q;
   assign mwr       = mwr_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign start_err = start_err_q;
endmodule
